// File: rtl/keccak_arbiter.sv
// keccak_arbiter
//   Shares a single keccak core (32-bit word input, 512-bit digest) between N
//   requester channels. Channels are served round-robin, one complete message
//   at a time: the core is cleared, the granted channel's words are forwarded
//   under the core's buffer_full back-pressure, the arbiter waits for the
//   digest (bounded by WAIT_LIMIT cycles) and hands it back tagged with the
//   owning channel id.
//
// Ports
//   clk, reset             clock (rising edge) and asynchronous active-high reset
//   req_valid/word/last/byte_num, req_ready
//                          per-channel word streams from the message sources;
//                          channel c uses req_word[32c+31:32c], req_byte_num[2c+1:2c]
//   core_reset, core_in, core_in_ready, core_is_last, core_byte_num
//                          drive side of the keccak core
//   core_buffer_full, core_out, core_out_ready
//                          status / digest from the keccak core
//   res_valid, res_id, res_digest, res_err, res_ready
//                          result handshake towards the consumer

module keccak_arbiter #(
  parameter int N          = 4,
  parameter int IDW        = 2,
  parameter int WAIT_LIMIT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      req_valid,
  input  logic [32*N-1:0]   req_word,
  input  logic [N-1:0]      req_last,
  input  logic [2*N-1:0]    req_byte_num,
  output logic [N-1:0]      req_ready,
  output logic              core_reset,
  output logic [31:0]       core_in,
  output logic              core_in_ready,
  output logic              core_is_last,
  output logic [1:0]        core_byte_num,
  input  logic              core_buffer_full,
  input  logic [511:0]      core_out,
  input  logic              core_out_ready,
  output logic              res_valid,
  output logic [IDW-1:0]    res_id,
  output logic [511:0]      res_digest,
  output logic              res_err,
  input  logic              res_ready
);

  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CW-1:0]  WAIT_MAX  = CW'(WAIT_LIMIT - 1);
  localparam logic [IDW-1:0] LAST_INIT = IDW'(N - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CLR  = 3'd1;
  localparam logic [2:0] ST_FEED = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [2:0]     state_r;
  logic [IDW-1:0] grant_r;
  logic [IDW-1:0] last_grant_r;
  logic [CW-1:0]  wait_cnt_r;
  logic           err_r;

  logic [IDW-1:0] pick_s;
  logic [IDW-1:0] cand_s;
  logic           accept_s;
  logic           timeout_s;

  // Round-robin pick: scan from last_grant+N down to last_grant+1 so the
  // nearest requester after last_grant overwrites any farther one.
  always_comb begin
    pick_s = last_grant_r;
    cand_s = last_grant_r;
    for (int i = N; i >= 1; i--) begin
      cand_s = IDW'((int'(last_grant_r) + i) % N);
      if (req_valid[cand_s]) begin
        pick_s = cand_s;
      end else begin
        pick_s = pick_s;
      end
    end
  end

  // A word moves only in FEED, from the granted channel, when the core has room.
  assign accept_s  = (state_r == ST_FEED) && req_valid[grant_r] && !core_buffer_full;

  // Timeout fires on the last WAIT cycle when the digest still has not arrived.
  assign timeout_s = (state_r == ST_WAIT) && !core_out_ready && (wait_cnt_r == WAIT_MAX);

  // Core is cleared during reset, for the single CLR cycle, and when a timed-out
  // message is abandoned so the core never keeps a half-processed state.
  assign core_reset    = reset || (state_r == ST_CLR) || timeout_s;
  assign core_in_ready = accept_s;

  // Only the granted channel sees ready, and only while the core can take a word.
  always_comb begin
    req_ready = '0;
    if (state_r == ST_FEED) begin
      req_ready[grant_r] = !core_buffer_full;
    end else begin
      req_ready = '0;
    end
  end

  // Word/last/byte_num mux from the granted channel, zeroed when nothing is forwarded.
  always_comb begin
    core_in       = 32'd0;
    core_is_last  = 1'b0;
    core_byte_num = 2'd0;
    if (accept_s) begin
      core_in       = req_word[32*grant_r +: 32];
      core_is_last  = req_last[grant_r];
      core_byte_num = req_byte_num[2*grant_r +: 2];
    end else begin
      core_in       = 32'd0;
      core_is_last  = 1'b0;
      core_byte_num = 2'd0;
    end
  end

  // Result side is driven only in DONE so every output idles at zero.
  always_comb begin
    res_valid  = 1'b0;
    res_id     = '0;
    res_err    = 1'b0;
    res_digest = 512'd0;
    if (state_r == ST_DONE) begin
      res_valid  = 1'b1;
      res_id     = grant_r;
      res_err    = err_r;
      res_digest = core_out;
    end else begin
      res_valid  = 1'b0;
      res_id     = '0;
      res_err    = 1'b0;
      res_digest = 512'd0;
    end
  end

  // Message-level state machine: arbitrate, clear core, feed, wait, deliver.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      grant_r      <= '0;
      last_grant_r <= LAST_INIT;
      wait_cnt_r   <= '0;
      err_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|req_valid) begin
            grant_r <= pick_s;
            state_r <= ST_CLR;
          end
        end
        ST_CLR: begin
          last_grant_r <= grant_r;
          state_r      <= ST_FEED;
        end
        ST_FEED: begin
          // No timeout here: a stalled requester simply keeps its grant.
          if (accept_s && req_last[grant_r]) begin
            wait_cnt_r <= '0;
            state_r    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (core_out_ready) begin
            err_r   <= 1'b0;
            state_r <= ST_DONE;
          end else if (wait_cnt_r == WAIT_MAX) begin
            err_r   <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            wait_cnt_r <= wait_cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_arbiter.sv
// Directed bench for keccak_arbiter. A behavioural stand-in for the keccak core
// folds accepted words into an order-sensitive 512-bit value; expected digests
// are that same fold applied to the stimulus words as a standalone run.
module tb_keccak_arbiter;

  localparam int N     = 4;
  localparam int IDW   = 2;
  localparam int WL    = 16;
  localparam int DEPTH = 128;
  localparam logic [511:0] INIT = 512'h1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req_valid;
  logic [32*N-1:0]   req_word;
  logic [N-1:0]      req_last;
  logic [2*N-1:0]    req_byte_num;
  logic [N-1:0]      req_ready;
  logic              core_reset;
  logic [31:0]       core_in;
  logic              core_in_ready;
  logic              core_is_last;
  logic [1:0]        core_byte_num;
  logic              core_buffer_full;
  logic [511:0]      core_out;
  logic              core_out_ready;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic [511:0]      res_digest;
  logic              res_err;
  logic              res_ready = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  keccak_arbiter #(.N(N), .IDW(IDW), .WAIT_LIMIT(WL)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_word(req_word), .req_last(req_last),
    .req_byte_num(req_byte_num), .req_ready(req_ready),
    .core_reset(core_reset), .core_in(core_in), .core_in_ready(core_in_ready),
    .core_is_last(core_is_last), .core_byte_num(core_byte_num),
    .core_buffer_full(core_buffer_full), .core_out(core_out),
    .core_out_ready(core_out_ready),
    .res_valid(res_valid), .res_id(res_id), .res_digest(res_digest),
    .res_err(res_err), .res_ready(res_ready)
  );

  // ---------------- requester word stores ----------------
  logic [31:0] mem_w [N][DEPTH];
  logic        mem_l [N][DEPTH];
  logic [1:0]  mem_b [N][DEPTH];
  int wr_ptr [N] = '{default: 0};
  int rd_ptr [N] = '{default: 0};
  int base   [N] = '{default: 0};

  // Present the head word of each channel while it has unsent words.
  always_comb begin
    req_valid    = '0;
    req_word     = '0;
    req_last     = '0;
    req_byte_num = '0;
    for (int c = 0; c < N; c++) begin
      if (rd_ptr[c] != wr_ptr[c]) begin
        req_valid[c]           = 1'b1;
        req_word[32*c +: 32]   = mem_w[c][rd_ptr[c]];
        req_last[c]            = mem_l[c][rd_ptr[c]];
        req_byte_num[2*c +: 2] = mem_b[c][rd_ptr[c]];
      end
    end
  end

  // Pop on handshake; a reset abandons a partial message and rewinds to its start.
  always @(posedge clk) begin
    for (int c = 0; c < N; c++) begin
      if (reset) begin
        if (rd_ptr[c] != wr_ptr[c]) rd_ptr[c] <= base[c];
      end else if (req_valid[c] && req_ready[c]) begin
        rd_ptr[c] <= rd_ptr[c] + 1;
      end
    end
  end

  // ---------------- core stand-in ----------------
  function automatic logic [511:0] mix(input logic [511:0] d, input logic [31:0] w,
                                       input logic [1:0] bn, input logic last);
    logic [511:0] r;
    r = {d[474:0], d[511:475]};
    r[34:0] = r[34:0] ^ {last, bn, w};
    r[511:480] = r[511:480] + w;
    return r;
  endfunction

  logic [511:0] acc = INIT;
  logic m_ready = 1'b0;
  logic hang = 1'b0;
  int lat = 0, full_cnt = 0, full_after = 0, words_acc = 0;
  int tot_words = 0, viol = 0, cr_cnt = 0, cyc = 0, last_edge = 0;

  assign core_buffer_full = (full_cnt > 0);
  assign core_out         = acc;
  assign core_out_ready   = m_ready;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_reset) cr_cnt <= cr_cnt + 1;
    if (core_in_ready) begin
      tot_words <= tot_words + 1;
      if (full_cnt > 0) viol <= viol + 1;
    end
    if (core_in_ready && !core_reset && (words_acc + 1 == full_after)) full_cnt <= 17;
    else if (full_cnt > 0) full_cnt <= full_cnt - 1;
    if (core_reset) begin
      acc <= INIT; m_ready <= 1'b0; lat <= 0; words_acc <= 0;
    end else if (core_in_ready) begin
      acc <= mix(acc, core_in, core_byte_num, core_is_last);
      words_acc <= words_acc + 1;
      if (core_is_last) begin
        lat <= 3;
        last_edge <= cyc + 1;
      end
    end else if (lat > 0) begin
      lat <= lat - 1;
      if (lat == 1 && !hang) m_ready <= 1'b1;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic push_word(input int c, input logic [31:0] w, input logic last, input logic [1:0] bn);
    mem_w[c][wr_ptr[c]] = w;
    mem_l[c][wr_ptr[c]] = last;
    mem_b[c][wr_ptr[c]] = bn;
    wr_ptr[c] = wr_ptr[c] + 1;
  endtask

  task automatic start_msg(input int c);
    base[c] = wr_ptr[c];
  endtask

  function automatic logic [511:0] digest_of(input int c, input int start, input int n);
    logic [511:0] d;
    d = INIT;
    for (int k = 0; k < n; k++) d = mix(d, mem_w[c][start+k], mem_b[c][start+k], mem_l[c][start+k]);
    return d;
  endfunction

  task automatic wait_res(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (res_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) check({tag, "_timeout"}, 512'd0, 512'd1);
  endtask

  task automatic get_result(input string tag, input int id, input logic err, input logic [511:0] dig);
    wait_res(tag);
    check({tag, "_valid"}, res_valid, 1'b1);
    check({tag, "_id"}, res_id, id[IDW-1:0]);
    check({tag, "_err"}, res_err, err);
    if (!err) check({tag, "_digest"}, res_digest, dig);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [511:0] d_exp;
  int tw0, crb, bad, b2, b0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_core_reset", core_reset, 1'b1);
    check("rst_outs", {req_ready, core_in_ready, res_valid, res_err, res_id, core_in}, 0);
    reset = 1'b0;
    #1;
    check("idle_outs", {core_reset, req_ready, core_in_ready, res_valid, res_digest}, 0);

    // 1: "Hello, world!" on ch0, with IDLE->CLR->FEED latency.
    @(negedge clk);
    start_msg(0); b0 = base[0];
    push_word(0, 32'h48656C6C, 1'b0, 2'd0);
    push_word(0, 32'h6F2C2077, 1'b0, 2'd0);
    push_word(0, 32'h6F726C64, 1'b0, 2'd0);
    push_word(0, 32'h21202020, 1'b1, 2'd1);
    @(negedge clk);
    check("t1_clr_pulse", {core_reset, req_ready}, {1'b1, 4'b0000});
    @(negedge clk);
    check("t1_first_ready", {core_reset, req_ready}, {1'b0, 4'b0001});
    get_result("t1", 0, 1'b0, digest_of(0, b0, 4));
    check("t1_words", words_acc, 4);

    // 2: all channels at once after reset -> rotation 0,1,2,3.
    pulse_reset();
    for (int c = 0; c < N; c++) begin
      start_msg(c);
      push_word(c, 32'h61626320, 1'b1, 2'd3);
    end
    d_exp = mix(INIT, 32'h61626320, 2'd3, 1'b1);
    for (int c = 0; c < N; c++) get_result($sformatf("t2_%0d", c), c, 1'b0, d_exp);
    repeat (20) @(negedge clk);
    check("t2_no_extra", res_valid, 1'b0);

    // 3: 20 words on ch1, core full for 17 cycles after word 18.
    full_after = 18;
    tw0 = tot_words;
    start_msg(1);
    for (int k = 0; k < 20; k++) push_word(1, 32'h1000_0000 + k * 32'h0101_0303, (k == 19), (k == 19) ? 2'd2 : 2'd0);
    get_result("t3", 1, 1'b0, digest_of(1, base[1], 20));
    check("t3_pulses", tot_words - tw0, 20);
    check("t3_no_word_while_full", viol, 0);
    full_after = 0;

    // 4: core never answers -> timeout exactly 16 cycles after entering WAIT.
    hang = 1'b1;
    start_msg(3);
    push_word(3, 32'hDEADBEEF, 1'b0, 2'd0);
    push_word(3, 32'hCAFEF00D, 1'b1, 2'd2);
    wait_res("t4");
    check("t4_latency", cyc - last_edge, 16);
    get_result("t4", 3, 1'b1, 512'd0);
    hang = 1'b0;
    crb = cr_cnt;
    start_msg(0); b0 = base[0];
    push_word(0, 32'h01020304, 1'b1, 2'd0);
    get_result("t4_next", 0, 1'b0, digest_of(0, b0, 1));
    check("t4_next_clr", cr_cnt - crb, 1);
    check("t4_next_words", words_acc, 1);

    // 5: reset while ch2 is at word 3 of 11, then full resend.
    start_msg(2); b2 = base[2];
    for (int k = 0; k < 11; k++) push_word(2, 32'hA5000000 + k * 32'h0001_1111, (k == 10), (k == 10) ? 2'd1 : 2'd0);
    for (int i = 0; i < 500; i++) begin
      if (rd_ptr[2] - b2 == 3) break;
      @(negedge clk);
    end
    check("t5_reached_word3", rd_ptr[2] - b2, 3);
    reset = 1'b1;
    @(negedge clk);
    check("t5_in_reset", {core_reset, req_ready, core_in_ready, res_valid}, {1'b1, 4'b0000, 1'b0, 1'b0});
    reset = 1'b0;
    #1;
    check("t5_idle_outs", {core_reset, req_ready, core_in_ready, core_in, res_valid, res_id, res_err, res_digest}, 0);
    get_result("t5", 2, 1'b0, digest_of(2, b2, 11));
    check("t5_words", words_acc, 11);

    // 6: result held 50 cycles with ch1 pending.
    @(negedge clk);
    start_msg(0); b0 = base[0];
    push_word(0, 32'h11111111, 1'b1, 2'd1);
    start_msg(1);
    push_word(1, 32'h22222222, 1'b1, 2'd2);
    d_exp = digest_of(0, b0, 1);
    wait_res("t6a");
    check("t6_first_id", res_id, 2'd0);
    crb = cr_cnt;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!res_valid || res_id !== 2'd0 || res_digest !== d_exp) bad++;
    end
    check("t6_stable", bad, 0);
    check("t6_no_clr", cr_cnt - crb, 0);
    get_result("t6a", 0, 1'b0, d_exp);
    get_result("t6b", 1, 1'b0, digest_of(1, base[1], 1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
